rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Writeback-port arbiter and scoreboard for the pipelined core's register file. Shares the file's single write port (we3/wa3/wd3, written on the falling clock edge) between the in-order pipeline Writeback stage and a long-latency multicycle unit (divider/load miss path). Buffers multicycle results in a small FIFO, tracks pending destination registers, and generates the Decode-stage stall for RAW/WAW hazards against them.

## Interface
Parameters:
- WIDTH, 32, data width of register file entries
- QDEPTH, 2, multicycle result FIFO depth (power of two, ≥2)
- STARVE, 8, cycles a queued result may wait before forcing the port

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- pipe_we  in  1  pipeline WB write request
- pipe_wa  in  5  pipeline WB destination
- pipe_wd  in  WIDTH  pipeline WB data
- wb_hold  out  1  pipeline WB stage must hold and re-present its write next cycle
- mc_issue  in  1  multicycle op issued this cycle (only when stall_d=0)
- mc_issue_rd  in  5  destination of issued op
- mc_valid  in  1  multicycle result valid
- mc_wa  in  5  result destination
- mc_wd  in  WIDTH  result data
- mc_ready  out  1  FIFO can accept a result
- rs1_d, rs2_d, rd_d  in  5 each  Decode-stage source/destination registers
- stall_d  out  1  Decode must stall
- busy  out  32  scoreboard, bit r = result pending for xr
- we3  out  1  register file write enable
- wa3  out  5  register file write address
- wd3  out  WIDTH  register file write data

## Operation
- Pipeline request valid only if pipe_we=1 and pipe_wa≠0; x0 writes never reach the port.
- Multicycle results always pass through the FIFO (no bypass). Accept when mc_valid & mc_ready; mc_ready = !full & !reset. Results with mc_wa=0 are accepted and discarded (not enqueued).
- Port grant, per cycle (combinational):
  - starve forced (counter==STARVE, FIFO non-empty): drive FIFO head, pop; wb_hold=1 if pipeline request valid, else 0.
  - else pipeline request valid: drive pipe_wa/pipe_wd, we3=1.
  - else FIFO non-empty: drive head, pop.
  - else we3=0, wa3=0, wd3=0.
- Starvation counter: cleared on pop or when FIFO empty; else increments each cycle, saturating at STARVE.
- Scoreboard: mc_issue with mc_issue_rd≠0 sets busy[rd]; a pop clears busy[head wa]. Set and clear to the same register in one cycle: set wins.
- stall_d = any of rs1_d, rs2_d, rd_d is nonzero and busy after masking the register popped this cycle (falling-edge write makes it readable same cycle).
- Simultaneous accept and pop on a full FIFO is not allowed: mc_ready depends only on registered full.

## Timing
- Reset values: FIFO empty, busy=0, counter=0, stall_d=0, wb_hold=0, we3=0, wa3=0, wd3=0, mc_ready=0 while reset asserted, 1 the cycle after.
- Reset mid-operation discards all queued results and clears busy; any in-flight multicycle op must be flushed externally.
- Multicycle result latency: accepted at edge N, earliest write in cycle N+1 (FIFO head visible after edge).
- Max port wait for a queued result: STARVE cycles after reaching head.
- stall_d is combinational from rs*/rd_d, busy and the current pop.
- FIFO pointers wrap modulo QDEPTH; full/empty distinguished by extra pointer bit.

## Test plan
- Reset, then idle: busy=0, we3=0, mc_ready=1 from first post-reset cycle; pipe_we=1, wa=0 -> we3=0.
- Issue rd=5, later mc result (5, 0xDEAD_BEEF) with no pipe traffic -> we3=1, wa3=5, wd3=0xDEADBEEF one cycle after accept; stall_d on rs1_d=5 high until that cycle, low in it.
- Continuous pipe_we to x7 with two queued results -> FIFO full, mc_ready=0; after 8 waiting cycles queue forced, wb_hold=1 exactly that cycle, pipe write to x7 lands next cycle.
- Pop of x9 coincident with new mc_issue rd=9 -> busy[9] remains 1.
- Result with mc_wa=0 -> no enqueue, no write; reset asserted with 2 queued entries -> no further we3, busy=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// +-------------------------------------------------------------------------+
// | rf_wb_arbiter: shares the register-file write port between the pipeline  |
// | WB stage and a queued multicycle unit; scoreboards pending dests. Rev 1.0|
// +-------------------------------------------------------------------------+
`default_nettype none

module rf_wb_arbiter #(
  parameter int WIDTH  = 32,
  parameter int QDEPTH = 2,
  parameter int STARVE = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pipe_we,
  input  logic [4:0]       pipe_wa,
  input  logic [WIDTH-1:0] pipe_wd,
  output logic             wb_hold,
  input  logic             mc_issue,
  input  logic [4:0]       mc_issue_rd,
  input  logic             mc_valid,
  input  logic [4:0]       mc_wa,
  input  logic [WIDTH-1:0] mc_wd,
  output logic             mc_ready,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rd_d,
  output logic             stall_d,
  output logic [31:0]      busy,
  output logic             we3,
  output logic [4:0]       wa3,
  output logic [WIDTH-1:0] wd3
);

  localparam int c_aw = $clog2(QDEPTH);
  localparam int c_cw = $clog2(STARVE + 1);
  localparam logic [c_cw-1:0] c_starve = c_cw'(STARVE);

  logic [4:0]       r_fifo_wa [QDEPTH];
  logic [WIDTH-1:0] r_fifo_wd [QDEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic [c_cw-1:0]  r_cnt;
  logic [31:0]      r_busy;

  logic             w_empty;
  logic             w_full;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_pipe_valid;
  logic             w_forced;
  logic [4:0]       w_head_wa;
  logic [WIDTH-1:0] w_head_wd;
  logic [31:0]      w_busy_nxt;
  logic [31:0]      w_busy_vis;

  // The extra pointer bit separates full from empty when the index bits match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                     (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_head_wa = r_fifo_wa[r_rd_ptr[c_aw-1:0]];
  assign w_head_wd = r_fifo_wd[r_rd_ptr[c_aw-1:0]];

  assign mc_ready  = !w_full && !reset;
  assign w_accept  = mc_valid && mc_ready;
  assign w_push    = w_accept && (mc_wa != 5'd0);

  assign w_pipe_valid = pipe_we && (pipe_wa != 5'd0) && !reset;
  assign w_forced     = !w_empty && (r_cnt == c_starve) && !reset;

  always_comb begin
    we3     = 1'b0;
    wa3     = 5'd0;
    wd3     = '0;
    wb_hold = 1'b0;
    w_pop   = 1'b0;
    if (w_forced) begin
      we3     = 1'b1;
      wa3     = w_head_wa;
      wd3     = w_head_wd;
      w_pop   = 1'b1;
      wb_hold = w_pipe_valid;
    end else if (w_pipe_valid) begin
      we3 = 1'b1;
      wa3 = pipe_wa;
      wd3 = pipe_wd;
    end else if (!w_empty && !reset) begin
      we3   = 1'b1;
      wa3   = w_head_wa;
      wd3   = w_head_wd;
      w_pop = 1'b1;
    end
  end

  // Clear first so a same-cycle issue to the popped register keeps it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop) begin
      w_busy_nxt[w_head_wa] = 1'b0;
    end
    if (mc_issue && (mc_issue_rd != 5'd0)) begin
      w_busy_nxt[mc_issue_rd] = 1'b1;
    end
  end

  // The popped register is written on the falling edge, so Decode may read it now.
  always_comb begin
    w_busy_vis = r_busy;
    if (w_pop) begin
      w_busy_vis[w_head_wa] = 1'b0;
    end
    stall_d = !reset && (((rs1_d != 5'd0) && w_busy_vis[rs1_d]) ||
                         ((rs2_d != 5'd0) && w_busy_vis[rs2_d]) ||
                         ((rd_d  != 5'd0) && w_busy_vis[rd_d]));
  end

  assign busy = r_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_busy   <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_pop || w_empty) begin
        r_cnt <= '0;
      end else if (r_cnt != c_starve) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_wa[r_wr_ptr[c_aw-1:0]] <= mc_wa;
      r_fifo_wd[r_wr_ptr[c_aw-1:0]] <= mc_wd;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
// +-------------------------------------------------------------------------+
// | tb_rf_wb_arbiter: directed and random stimulus against a queue model.    |
// | Rev 1.0                                                                   |
// +-------------------------------------------------------------------------+
`default_nettype none

module tb_rf_wb_arbiter;

  localparam int WIDTH  = 32;
  localparam int QDEPTH = 2;
  localparam int STARVE = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             pipe_we;
  logic [4:0]       pipe_wa;
  logic [WIDTH-1:0] pipe_wd;
  logic             wb_hold;
  logic             mc_issue;
  logic [4:0]       mc_issue_rd;
  logic             mc_valid;
  logic [4:0]       mc_wa;
  logic [WIDTH-1:0] mc_wd;
  logic             mc_ready;
  logic [4:0]       rs1_d, rs2_d, rd_d;
  logic             stall_d;
  logic [31:0]      busy;
  logic             we3;
  logic [4:0]       wa3;
  logic [WIDTH-1:0] wd3;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.WIDTH(WIDTH), .QDEPTH(QDEPTH), .STARVE(STARVE)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_wa(pipe_wa), .pipe_wd(pipe_wd), .wb_hold(wb_hold),
    .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd),
    .mc_valid(mc_valid), .mc_wa(mc_wa), .mc_wd(mc_wd), .mc_ready(mc_ready),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .stall_d(stall_d), .busy(busy),
    .we3(we3), .wa3(wa3), .wd3(wd3)
  );

  typedef struct {
    logic [4:0]       wa;
    logic [WIDTH-1:0] wd;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_busy = '0;
  int          m_wait = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic zero_inputs();
    reset = 1'b0; pipe_we = 1'b0; pipe_wa = '0; pipe_wd = '0;
    mc_issue = 1'b0; mc_issue_rd = '0; mc_valid = 1'b0; mc_wa = '0; mc_wd = '0;
    rs1_d = '0; rs2_d = '0; rd_d = '0;
  endtask

  // Called just after a falling edge with inputs already set; returns at the next falling edge.
  task automatic step();
    logic             e_we, e_hold, e_ready, e_stall, pop, pv, ne;
    logic [4:0]       e_wa;
    logic [WIDTH-1:0] e_wd;
    logic [31:0]      vis;
    #1;
    e_we = 0; e_wa = '0; e_wd = '0; e_hold = 0; e_ready = 0; e_stall = 0; pop = 0;
    pv = pipe_we && (pipe_wa != 0);
    ne = (m_q.size() != 0);
    if (!reset) begin
      e_ready = (m_q.size() < QDEPTH);
      if (ne && m_wait >= STARVE) begin
        pop = 1; e_hold = pv;
      end else if (pv) begin
        e_we = 1; e_wa = pipe_wa; e_wd = pipe_wd;
      end else if (ne) begin
        pop = 1;
      end
      if (pop) begin
        e_we = 1; e_wa = m_q[0].wa; e_wd = m_q[0].wd;
      end
      vis = m_busy;
      if (pop) vis[m_q[0].wa] = 1'b0;
      e_stall = (rs1_d != 0 && vis[rs1_d]) || (rs2_d != 0 && vis[rs2_d]) ||
                (rd_d != 0 && vis[rd_d]);
    end
    chk("we3", we3, e_we);
    chk("wa3", wa3, e_wa);
    chk("wd3", wd3, e_wd);
    chk("wb_hold", wb_hold, e_hold);
    chk("mc_ready", mc_ready, e_ready);
    chk("stall_d", stall_d, e_stall);
    chk("busy", busy, m_busy);
    @(posedge clk);
    if (reset) begin
      m_q.delete();
      m_busy = '0;
      m_wait = 0;
    end else begin
      if (pop || !ne) m_wait = 0;
      else if (m_wait < STARVE) m_wait++;
      if (pop) begin
        m_busy[m_q[0].wa] = 1'b0;
        void'(m_q.pop_front());
      end
      if (mc_issue && mc_issue_rd != 0) m_busy[mc_issue_rd] = 1'b1;
      if (mc_valid && e_ready && mc_wa != 0) m_q.push_back('{wa: mc_wa, wd: mc_wd});
    end
    @(negedge clk);
  endtask

  initial begin
    zero_inputs();
    @(negedge clk);
    reset = 1; step(); step(); reset = 0;

    // x0 pipeline writes never reach the port
    pipe_we = 1; pipe_wa = 0; pipe_wd = '1; step(); pipe_we = 0;

    // issue x5, result arrives later; stall on rs1=x5 until the write cycle
    mc_issue = 1; mc_issue_rd = 5; step(); mc_issue = 0;
    rs1_d = 5; step(); step();
    mc_valid = 1; mc_wa = 5; mc_wd = 32'hDEAD_BEEF; step(); mc_valid = 0;
    step(); step(); rs1_d = 0;

    // continuous pipeline traffic starves two queued results
    pipe_we = 1; pipe_wa = 7; pipe_wd = 32'h7777_0007;
    mc_valid = 1; mc_wa = 3; mc_wd = 32'h3333; step();
    mc_wa = 4; mc_wd = 32'h4444; step();
    mc_wa = 6; mc_wd = 32'h6666; step();
    mc_valid = 0;
    for (int i = 0; i < 22; i++) step();
    pipe_we = 0; step();

    // pop of x9 coincides with a fresh issue to x9
    mc_issue = 1; mc_issue_rd = 9; step(); mc_issue = 0;
    mc_valid = 1; mc_wa = 9; mc_wd = 32'h9999; step(); mc_valid = 0;
    mc_issue = 1; mc_issue_rd = 9; rd_d = 9; step(); mc_issue = 0;
    step(); rd_d = 0;
    mc_valid = 1; mc_wa = 9; mc_wd = 32'h9009; step(); mc_valid = 0; step();

    // result to x0 is accepted and dropped
    mc_valid = 1; mc_wa = 0; mc_wd = 32'hBAD0; step(); mc_valid = 0; step();

    // reset with two queued entries
    pipe_we = 1; pipe_wa = 7; pipe_wd = 32'h7070;
    mc_issue = 1; mc_issue_rd = 12; step(); mc_issue = 0;
    mc_valid = 1; mc_wa = 12; mc_wd = 32'h1212; step();
    mc_wa = 13; mc_wd = 32'h1313; step(); mc_valid = 0;
    reset = 1; step(); reset = 0; pipe_we = 0;
    rs1_d = 12; step(); step(); rs1_d = 0;

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      reset       = ($urandom_range(0, 99) == 0);
      pipe_we     = ($urandom_range(0, 1) == 1);
      pipe_wa     = 5'($urandom_range(0, 15));
      pipe_wd     = $urandom;
      mc_issue    = ($urandom_range(0, 3) == 0);
      mc_issue_rd = 5'($urandom_range(0, 15));
      mc_valid    = ($urandom_range(0, 9) < 3);
      mc_wa       = 5'($urandom_range(0, 15));
      mc_wd       = $urandom;
      rs1_d       = 5'($urandom_range(0, 15));
      rs2_d       = 5'($urandom_range(0, 15));
      rd_d        = 5'($urandom_range(0, 15));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
